// File: rtl/pc_sequencer_if.sv
// Control/fetch bus between the pipeline environment (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic                     stall;
  logic                     do_branch;
  logic [ADDR_W-1:0]        br_target;
  logic                     do_jump;
  logic [ADDR_W-1:0]        jmp_target;
  logic [ADDR_W+WORD_W-1:0] fetch_pkt;
  logic [ADDR_W-1:0]        pc;
  logic                     halted;
  logic [ADDR_W-1:0]        halt_pc;
  logic [CNT_W-1:0]         run_cnt;
  logic [CNT_W-1:0]         redir_cnt;

  modport master (
    output stall, do_branch, br_target, do_jump, jmp_target, fetch_pkt,
    input  pc, halted, halt_pc, run_cnt, redir_cnt
  );

  modport slave (
    input  stall, do_branch, br_target, do_jump, jmp_target, fetch_pkt,
    output pc, halted, halt_pc, run_cnt, redir_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: sequential stepping, branch/jump redirect, stall hold,
// halt-word detection on the returned fetch packet, and saturating run/redirect counters.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       WORD_W    = 16,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(1),
  parameter logic [WORD_W-1:0] HALT_WORD = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PKT_W = ADDR_W + WORD_W;

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;

  logic [WORD_W-1:0] pkt_word_c;
  logic [ADDR_W-1:0] pkt_pc_c;
  logic              halt_det_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pkt_word_c = bus.fetch_pkt[WORD_W-1:0];
  assign pkt_pc_c   = bus.fetch_pkt[PKT_W-1:WORD_W];
  // A redirect squashes the packet in flight; an all-zero bubble is never a halt.
  assign halt_det_c = (pkt_word_c == HALT_WORD) && (|bus.fetch_pkt)
                      && !bus.do_branch && !bus.do_jump;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_pc_d   = halt_pc_q;
    run_cnt_d   = run_cnt_q;
    redir_cnt_d = redir_cnt_q;
    case (state_q)
      S_RUN: begin
        if (halt_det_c) begin
          state_d   = S_HALTED;
          pc_d      = pkt_pc_c;
          halt_pc_d = pkt_pc_c;
        end else if (bus.do_jump) begin
          pc_d        = bus.jmp_target;
          run_cnt_d   = sat_inc(run_cnt_q);
          redir_cnt_d = sat_inc(redir_cnt_q);
        end else if (bus.do_branch) begin
          pc_d        = bus.br_target;
          run_cnt_d   = sat_inc(run_cnt_q);
          redir_cnt_d = sat_inc(redir_cnt_q);
        end else if (!bus.stall) begin
          pc_d      = pc_q + ADDR_W'(1);
          run_cnt_d = sat_inc(run_cnt_q);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      halt_pc_q   <= '0;
      run_cnt_q   <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_pc_q   <= halt_pc_d;
      run_cnt_q   <= run_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.halted    = (state_q == S_HALTED);
  assign bus.halt_pc   = halt_pc_q;
  assign bus.run_cnt   = run_cnt_q;
  assign bus.redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against an arithmetic reference model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model state, plain integers.
  int m_pc, m_halted, m_hpc, m_run, m_redir;

  pc_sequencer_if #(.ADDR_W(9), .WORD_W(16), .CNT_W(16)) bus ();

  pc_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic set_idle();
    bus.stall      = 1'b0;
    bus.do_branch  = 1'b0;
    bus.br_target  = '0;
    bus.do_jump    = 1'b0;
    bus.jmp_target = '0;
    bus.fetch_pkt  = '0;
  endtask

  // Advance one clock; the model computes the next architectural state from the same inputs.
  task automatic tick();
    int n_pc, n_halted, n_hpc, n_run, n_redir, word, ppc;
    n_pc = m_pc; n_halted = m_halted; n_hpc = m_hpc; n_run = m_run; n_redir = m_redir;
    word = int'(bus.fetch_pkt[15:0]);
    ppc  = int'(bus.fetch_pkt[24:16]);
    if (rst) begin
      n_pc = 1; n_halted = 0; n_hpc = 0; n_run = 0; n_redir = 0;
    end else if (m_halted == 0) begin
      if (word == 65535 && !bus.do_branch && !bus.do_jump) begin
        n_halted = 1; n_pc = ppc; n_hpc = ppc;
      end else if (bus.do_jump) begin
        n_pc = int'(bus.jmp_target); n_run = sat(m_run + 1); n_redir = sat(m_redir + 1);
      end else if (bus.do_branch) begin
        n_pc = int'(bus.br_target); n_run = sat(m_run + 1); n_redir = sat(m_redir + 1);
      end else if (!bus.stall) begin
        n_pc = (m_pc + 1) % 512; n_run = sat(m_run + 1);
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_halted = n_halted; m_hpc = n_hpc; m_run = n_run; m_redir = n_redir;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    checks++; if (bus.pc !== 9'd1) begin errors++; $display("FAIL reset_pc: got %0d expected 1", bus.pc); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", bus.halted); end
    checks++; if (bus.halt_pc !== 9'd0) begin errors++; $display("FAIL reset_halt_pc: got %0d expected 0", bus.halt_pc); end
    checks++; if (bus.run_cnt !== 16'd0) begin errors++; $display("FAIL reset_run_cnt: got %0d expected 0", bus.run_cnt); end
    checks++; if (bus.redir_cnt !== 16'd0) begin errors++; $display("FAIL reset_redir_cnt: got %0d expected 0", bus.redir_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.pc !== 9'(2 + i) || bus.run_cnt !== 16'(1 + i)) begin
        errors++;
        $display("FAIL release_step%0d: got pc=%0d run=%0d expected pc=%0d run=%0d", i, bus.pc, bus.run_cnt, 2 + i, 1 + i);
      end
    end
  endtask

  task automatic test_stall();
    int run_before;
    tick();
    tick();
    checks++; if (bus.pc !== 9'd5) begin errors++; $display("FAIL stall_setup_pc: got %0d expected 5", bus.pc); end
    run_before = m_run;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc !== 9'd5 || bus.run_cnt !== 16'(run_before)) begin
        errors++;
        $display("FAIL stall_hold%0d: got pc=%0d run=%0d expected pc=5 run=%0d", i, bus.pc, bus.run_cnt, run_before);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.pc !== 9'd6) begin errors++; $display("FAIL stall_release_pc: got %0d expected 6", bus.pc); end
  endtask

  task automatic test_redirect();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (bus.pc !== 9'd10) begin errors++; $display("FAIL redir_setup_pc: got %0d expected 10", bus.pc); end
    bus.do_branch = 1'b1; bus.br_target = 9'd4;
    tick();
    checks++; if (bus.pc !== 9'd4) begin errors++; $display("FAIL branch_pc: got %0d expected 4", bus.pc); end
    checks++; if (bus.redir_cnt !== 16'd1) begin errors++; $display("FAIL branch_redir_cnt: got %0d expected 1", bus.redir_cnt); end
    bus.do_jump = 1'b1; bus.jmp_target = 9'd20;
    tick();
    checks++; if (bus.pc !== 9'd20) begin errors++; $display("FAIL jump_beats_branch_pc: got %0d expected 20", bus.pc); end
    checks++; if (bus.redir_cnt !== 16'd2) begin errors++; $display("FAIL jump_redir_cnt: got %0d expected 2", bus.redir_cnt); end
    checks++; if (bus.run_cnt !== 16'd11) begin errors++; $display("FAIL redir_run_cnt: got %0d expected 11", bus.run_cnt); end
    set_idle();
  endtask

  task automatic test_halt();
    int run_s, redir_s;
    bus.fetch_pkt = {9'd11, 16'hFFFF};
    tick();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b expected 1", bus.halted); end
    checks++; if (bus.pc !== 9'd11) begin errors++; $display("FAIL halt_pc_out: got %0d expected 11", bus.pc); end
    checks++; if (bus.halt_pc !== 9'd11) begin errors++; $display("FAIL halt_pc_reg: got %0d expected 11", bus.halt_pc); end
    run_s = m_run; redir_s = m_redir;
    bus.do_jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.jmp_target = 9'($urandom);
      bus.stall      = 1'($urandom);
      tick();
      checks++;
      if (bus.pc !== 9'd11 || bus.halted !== 1'b1 || bus.run_cnt !== 16'(run_s) || bus.redir_cnt !== 16'(redir_s)) begin
        errors++;
        $display("FAIL halt_frozen%0d: got pc=%0d halted=%0b run=%0d redir=%0d expected pc=11 halted=1 run=%0d redir=%0d",
                 i, bus.pc, bus.halted, bus.run_cnt, bus.redir_cnt, run_s, redir_s);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    checks++;
    if (bus.pc !== 9'd1 || bus.halted !== 1'b0 || bus.run_cnt !== 16'd0 || bus.redir_cnt !== 16'd0 || bus.halt_pc !== 9'd0) begin
      errors++;
      $display("FAIL reset_from_halt: got pc=%0d halted=%0b run=%0d redir=%0d hpc=%0d expected 1,0,0,0,0",
               bus.pc, bus.halted, bus.run_cnt, bus.redir_cnt, bus.halt_pc);
    end
    bus.do_branch = 1'b1; bus.br_target = 9'd30;
    tick();
    bus.do_branch = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.pc !== 9'd1 || bus.halted !== 1'b0 || bus.run_cnt !== 16'd0 || bus.redir_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_during_stall: got pc=%0d halted=%0b run=%0d redir=%0d expected 1,0,0,0",
               bus.pc, bus.halted, bus.run_cnt, bus.redir_cnt);
    end
    set_idle();
  endtask

  task automatic test_squash_wrap();
    bus.fetch_pkt = {9'd7, 16'hFFFF};
    bus.do_branch = 1'b1; bus.br_target = 9'd3;
    tick();
    checks++; if (bus.pc !== 9'd3 || bus.halted !== 1'b0) begin errors++; $display("FAIL squash: got pc=%0d halted=%0b expected pc=3 halted=0", bus.pc, bus.halted); end
    set_idle();
    bus.fetch_pkt = '0;
    tick();
    checks++; if (bus.halted !== 1'b0 || bus.pc !== 9'd4) begin errors++; $display("FAIL bubble_no_halt: got pc=%0d halted=%0b expected pc=4 halted=0", bus.pc, bus.halted); end
    bus.do_jump = 1'b1; bus.jmp_target = 9'd511;
    tick();
    bus.do_jump = 1'b0;
    checks++; if (bus.pc !== 9'd511) begin errors++; $display("FAIL wrap_setup_pc: got %0d expected 511", bus.pc); end
    tick();
    checks++; if (bus.pc !== 9'd0 || bus.halted !== 1'b0) begin errors++; $display("FAIL wrap_pc: got pc=%0d halted=%0b expected pc=0 halted=0", bus.pc, bus.halted); end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      bus.stall      = ($urandom_range(0, 99) < 25);
      bus.do_branch  = ($urandom_range(0, 99) < 10);
      bus.do_jump    = ($urandom_range(0, 99) < 8);
      bus.br_target  = 9'($urandom);
      bus.jmp_target = 9'($urandom);
      sel = int'($urandom_range(0, 99));
      if (sel < 40)      bus.fetch_pkt = '0;
      else if (sel < 44) bus.fetch_pkt = {9'($urandom), 16'hFFFF};
      else               bus.fetch_pkt = 25'($urandom);
      tick();
      checks++;
      if (bus.pc !== 9'(m_pc) || bus.halted !== 1'(m_halted) || bus.halt_pc !== 9'(m_hpc)
          || bus.run_cnt !== 16'(m_run) || bus.redir_cnt !== 16'(m_redir)) begin
        errors++;
        $display("FAIL random%0d: got pc=%0d h=%0b hpc=%0d run=%0d redir=%0d expected pc=%0d h=%0d hpc=%0d run=%0d redir=%0d",
                 i, bus.pc, bus.halted, bus.halt_pc, bus.run_cnt, bus.redir_cnt, m_pc, m_halted, m_hpc, m_run, m_redir);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    m_pc = 0; m_halted = 0; m_hpc = 0; m_run = 0; m_redir = 0;
    rst = 1'b1;
    set_idle();
    #2;
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_mid_reset();
    test_squash_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
